// File: rtl/uart_cmd_parser.sv
// Framed command parser between the UART RX FIFO and game logic: assembles
// SYNC/CMD/LEN/PAYLOAD/CSUM frames and queues a one-byte ACK/NAK into the TX FIFO.
module uart_cmd_parser #(
  parameter logic [7:0] SYNC_BYTE      = 8'hA5,
  parameter int         TIMEOUT_CYCLES = 2_500_000,
  parameter int         ACK_EN         = 1,
  parameter logic [7:0] ACK_BYTE       = 8'h06,
  parameter logic [7:0] NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        rx_rdempty,
  output logic        rx_read,
  input  logic [7:0]  rx_readdata,
  input  logic        tx_wrfull,
  output logic        tx_write,
  output logic [7:0]  tx_writedata,
  output logic        cmd_valid,
  output logic [7:0]  cmd_code,
  output logic [2:0]  cmd_len,
  output logic [31:0] cmd_payload,
  output logic        cmd_error,
  output logic [1:0]  err_code
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_CMD     = 3'd1,
    S_LEN     = 3'd2,
    S_PAYLOAD = 3'd3,
    S_CSUM    = 3'd4
  } state_t;

  localparam logic [1:0]  ERR_LEN  = 2'd1;
  localparam logic [1:0]  ERR_CSUM = 2'd2;
  localparam logic [1:0]  ERR_TO   = 2'd3;
  localparam logic        ACK_ON   = (ACK_EN != 0);
  // cnt_r holds cycles elapsed since the last byte, so firing at TIMEOUT_CYCLES-2
  // puts the registered error strobe exactly TIMEOUT_CYCLES-1 cycles after it.
  localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CYCLES - 2);

  function automatic logic [7:0] csum_fold(input logic [7:0] acc, input logic [7:0] b);
    return acc ^ b;
  endfunction

  function automatic logic [31:0] put_byte(input logic [31:0] word, input logic [1:0] idx,
                                           input logic [7:0] b);
    logic [31:0] r;
    r = word;
    case (idx)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      2'd3:    r[31:24] = b;
      default: r        = word;
    endcase
    return r;
  endfunction

  state_t      state_r, state_n;
  logic        byte_valid_r;
  logic [7:0]  cmd_r, cmd_n;
  logic [2:0]  len_r, len_n;
  logic [1:0]  idx_r, idx_n;
  logic [31:0] pay_r, pay_n;
  logic [7:0]  csum_r, csum_n;
  logic [31:0] cnt_r;
  logic        pend_r;
  logic [7:0]  pend_data_r;

  logic        good_s;
  logic        bad_s;
  logic [1:0]  bad_code_s;
  logic        resp_s;
  logic [7:0]  resp_byte_s;
  logic        timeout_s;

  // Fetch unit: one pop at a time, the popped byte is valid the following cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rx_read      <= 1'b0;
      byte_valid_r <= 1'b0;
    end else begin
      rx_read      <= !rx_rdempty && !rx_read;
      byte_valid_r <= rx_read;
    end
  end

  // Frame FSM next-state, field capture and strobe decode.
  always_comb begin
    state_n     = state_r;
    cmd_n       = cmd_r;
    len_n       = len_r;
    idx_n       = idx_r;
    pay_n       = pay_r;
    csum_n      = csum_r;
    good_s      = 1'b0;
    bad_s       = 1'b0;
    bad_code_s  = 2'd0;
    resp_s      = 1'b0;
    resp_byte_s = 8'h00;
    timeout_s   = (state_r != S_IDLE) && !byte_valid_r && (cnt_r >= TO_LIMIT);

    if (byte_valid_r) begin
      case (state_r)
        S_IDLE: begin
          if (rx_readdata == SYNC_BYTE) begin
            state_n = S_CMD;
          end else begin
            state_n = S_IDLE;
          end
        end
        S_CMD: begin
          cmd_n   = rx_readdata;
          csum_n  = rx_readdata;
          state_n = S_LEN;
        end
        S_LEN: begin
          if (rx_readdata > 8'd4) begin
            bad_s       = 1'b1;
            bad_code_s  = ERR_LEN;
            resp_s      = 1'b1;
            resp_byte_s = NAK_BYTE;
            state_n     = S_IDLE;
          end else begin
            len_n   = rx_readdata[2:0];
            csum_n  = csum_fold(csum_r, rx_readdata);
            pay_n   = 32'h0000_0000;
            idx_n   = 2'd0;
            if (rx_readdata == 8'd0) begin
              state_n = S_CSUM;
            end else begin
              state_n = S_PAYLOAD;
            end
          end
        end
        S_PAYLOAD: begin
          pay_n  = put_byte(pay_r, idx_r, rx_readdata);
          csum_n = csum_fold(csum_r, rx_readdata);
          idx_n  = idx_r + 2'd1;
          if ({1'b0, idx_r} == (len_r - 3'd1)) begin
            state_n = S_CSUM;
          end else begin
            state_n = S_PAYLOAD;
          end
        end
        S_CSUM: begin
          resp_s = 1'b1;
          if (rx_readdata == csum_r) begin
            good_s      = 1'b1;
            resp_byte_s = ACK_BYTE;
          end else begin
            bad_s       = 1'b1;
            bad_code_s  = ERR_CSUM;
            resp_byte_s = NAK_BYTE;
          end
          state_n = S_IDLE;
        end
        default: state_n = S_IDLE;
      endcase
    end else if (timeout_s) begin
      bad_s      = 1'b1;
      bad_code_s = ERR_TO;
      state_n    = S_IDLE;
    end else begin
      state_n = state_r;
    end
  end

  // Frame state, working fields and inter-byte timeout counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= S_IDLE;
      cmd_r   <= 8'h00;
      len_r   <= 3'd0;
      idx_r   <= 2'd0;
      pay_r   <= 32'h0000_0000;
      csum_r  <= 8'h00;
      cnt_r   <= 32'd0;
    end else begin
      state_r <= state_n;
      cmd_r   <= cmd_n;
      len_r   <= len_n;
      idx_r   <= idx_n;
      pay_r   <= pay_n;
      csum_r  <= csum_n;
      if (state_n == S_IDLE) begin
        cnt_r <= 32'd0;
      end else if (byte_valid_r) begin
        cnt_r <= 32'd1;
      end else begin
        cnt_r <= cnt_r + 32'd1;
      end
    end
  end

  // Result strobes and held command/error outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cmd_valid   <= 1'b0;
      cmd_error   <= 1'b0;
      cmd_code    <= 8'h00;
      cmd_len     <= 3'd0;
      cmd_payload <= 32'h0000_0000;
      err_code    <= 2'd0;
    end else begin
      cmd_valid <= good_s;
      cmd_error <= bad_s;
      if (good_s) begin
        cmd_code    <= cmd_r;
        cmd_len     <= len_r;
        cmd_payload <= pay_r;
      end
      if (bad_s) begin
        err_code <= bad_code_s;
      end
    end
  end

  // One-entry response slot; a fresh response replaces one still waiting on a full FIFO.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pend_r       <= 1'b0;
      pend_data_r  <= 8'h00;
      tx_write     <= 1'b0;
      tx_writedata <= 8'h00;
    end else begin
      tx_write <= ACK_ON && pend_r && !tx_wrfull;
      if (ACK_ON && pend_r && !tx_wrfull) begin
        tx_writedata <= pend_data_r;
      end
      if (resp_s) begin
        pend_r      <= 1'b1;
        pend_data_r <= resp_byte_s;
      end else if (pend_r && !tx_wrfull) begin
        pend_r <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_parser.sv
// Self-checking bench for uart_cmd_parser: directed frames plus randomized frames
// scored against a frame-level model of the byte stream.
module tb_uart_cmd_parser;

  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_rdempty = 1'b1;
  logic        rx_read;
  logic [7:0]  rx_readdata = 8'h00;
  logic        tx_wrfull = 1'b0;
  logic        tx_write;
  logic [7:0]  tx_writedata;
  logic        cmd_valid;
  logic [7:0]  cmd_code;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        cmd_error;
  logic [1:0]  err_code;

  uart_cmd_parser #(
    .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TO), .ACK_EN(1),
    .ACK_BYTE(8'h06), .NAK_BYTE(8'h15)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .rx_rdempty(rx_rdempty), .rx_read(rx_read), .rx_readdata(rx_readdata),
    .tx_wrfull(tx_wrfull), .tx_write(tx_write), .tx_writedata(tx_writedata),
    .cmd_valid(cmd_valid), .cmd_code(cmd_code), .cmd_len(cmd_len),
    .cmd_payload(cmd_payload), .cmd_error(cmd_error), .err_code(err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        good;
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] pay;
    logic [1:0]  err;
    int          cyc;
    int          lrd;
  } ev_t;

  typedef struct {
    logic        good;
    logic [7:0]  code;
    logic [2:0]  len;
    logic [31:0] pay;
    logic [1:0]  err;
    logic [7:0]  resp;
  } exp_t;

  logic [7:0] src_q[$];
  logic [7:0] rxq[$];
  logic [7:0] stim[$];
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];
  ev_t        ev_q[$];
  exp_t       exp_q[$];

  int src_idx = 0;
  int gap_run = 0;
  int gap_pct = 0;
  int underflow = 0;
  int anomaly = 0;
  int cyc = 0;
  int last_rd = 0;
  int ev_rd = 0;
  int tx_rd = 0;
  int checks = 0;
  int errors = 0;

  logic [7:0]  held_code = 8'h00;
  logic [2:0]  held_len = 3'd0;
  logic [31:0] held_pay = 32'h0;
  logic [1:0]  held_err = 2'd0;

  // RX FIFO model: non-show-ahead, fed from src_q with short random arrival gaps.
  always @(posedge clk) begin
    if (!reset_n) begin
      rxq.delete();
      src_idx    <= src_q.size();
      rx_rdempty <= 1'b1;
      gap_run    <= 0;
    end else begin
      if (rx_read) begin
        if (rxq.size() == 0) underflow <= underflow + 1;
        else rx_readdata <= rxq.pop_front();
      end
      if (src_idx < src_q.size() && (gap_run >= 3 || $urandom_range(0, 99) >= gap_pct)) begin
        rxq.push_back(src_q[src_idx]);
        src_idx <= src_idx + 1;
        gap_run <= 0;
      end else begin
        gap_run <= gap_run + 1;
      end
      rx_rdempty <= (rxq.size() == 0);
    end
  end

  // Output monitor, sampled on the falling edge.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (rx_read) last_rd <= cyc;
    if (cmd_valid || cmd_error)
      ev_q.push_back('{cmd_valid, cmd_code, cmd_len, cmd_payload, err_code, cyc, last_rd});
    if ((cmd_valid && cmd_error) || (tx_write && tx_wrfull)) anomaly <= anomaly + 1;
    if (tx_write) begin
      tx_q.push_back(tx_writedata);
      tx_cyc_q.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [63:0] bytes, input int n);
    for (int k = n - 1; k >= 0; k--) stim.push_back(bytes[8*k +: 8]);
  endtask

  task automatic send_raw();
    foreach (stim[k]) src_q.push_back(stim[k]);
    stim.delete();
  endtask

  // Frame-level reference: scan the stream for complete frames and list the expected results.
  task automatic model_and_send();
    int i;
    int n;
    int len;
    logic [7:0]  cs;
    logic [31:0] pay;
    n = stim.size();
    i = 0;
    while (i < n) begin
      if (stim[i] != 8'hA5 || i + 2 >= n) begin
        i++;
        continue;
      end
      len = int'(stim[i+2]);
      if (len > 4) begin
        held_err = 2'd1;
        exp_q.push_back('{1'b0, held_code, held_len, held_pay, held_err, 8'h15});
        i += 3;
        continue;
      end
      cs  = stim[i+1] ^ stim[i+2];
      pay = 32'h0;
      for (int k = 0; k < len; k++) begin
        pay = pay | (32'(stim[i+3+k]) << (8 * k));
        cs  = cs ^ stim[i+3+k];
      end
      if (stim[i+3+len] == cs) begin
        held_code = stim[i+1];
        held_len  = 3'(len);
        held_pay  = pay;
        exp_q.push_back('{1'b1, held_code, held_len, held_pay, held_err, 8'h06});
      end else begin
        held_err = 2'd2;
        exp_q.push_back('{1'b0, held_code, held_len, held_pay, held_err, 8'h15});
      end
      i += 4 + len;
    end
    send_raw();
  endtask

  task automatic drain(input int extra);
    int budget;
    budget = 3000;
    while ((src_idx < src_q.size() || !rx_rdempty) && budget > 0) begin
      @(negedge clk);
      budget--;
    end
    chk("drain_budget", 64'(budget > 0), 64'(1));
    repeat (extra) @(negedge clk);
  endtask

  task automatic verify(input string tag, input logic tx_lat);
    ev_t  o;
    exp_t e;
    chk({tag, "_ev_count"}, 64'(ev_q.size() - ev_rd), 64'(exp_q.size()));
    chk({tag, "_tx_count"}, 64'(tx_q.size() - tx_rd), 64'(exp_q.size()));
    while (exp_q.size() > 0 && ev_rd < ev_q.size()) begin
      e = exp_q.pop_front();
      o = ev_q[ev_rd];
      ev_rd++;
      chk({tag, "_valid"}, 64'(o.good), 64'(e.good));
      chk({tag, "_code"}, 64'(o.code), 64'(e.code));
      chk({tag, "_len"}, 64'(o.len), 64'(e.len));
      chk({tag, "_payload"}, 64'(o.pay), 64'(e.pay));
      chk({tag, "_err"}, 64'(o.err), 64'(e.err));
      chk({tag, "_latency"}, 64'(o.cyc - o.lrd), 64'(2));
      if (tx_rd < tx_q.size()) begin
        chk({tag, "_txdata"}, 64'(tx_q[tx_rd]), 64'(e.resp));
        if (tx_lat) chk({tag, "_txlat"}, 64'(tx_cyc_q[tx_rd] - o.cyc), 64'(1));
        tx_rd++;
      end
    end
    exp_q.delete();
    ev_rd = ev_q.size();
    tx_rd = tx_q.size();
  endtask

  initial begin
    ev_t o;
    int nj;
    int kind;
    int len;
    logic [7:0] b;
    logic [7:0] cs;

    repeat (3) @(negedge clk);
    chk("rst_strobes", 64'({rx_read, tx_write, cmd_valid, cmd_error}), 64'(0));
    chk("rst_cmd", 64'({cmd_code, cmd_len, cmd_payload}), 64'(0));
    chk("rst_err_tx", 64'({err_code, tx_writedata}), 64'(0));
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // 0x10^0x02^0x34^0x12 = 0x34
    put(64'hA5_10_02_34_12_34, 6);
    model_and_send();
    drain(8);
    verify("good2", 1'b1);
    chk("good2_outputs", 64'({cmd_code, cmd_len, cmd_payload}), 64'({8'h10, 3'd2, 32'h0000_1234}));

    put(64'h00_FF_A5_07_00_07, 6);
    model_and_send();
    drain(8);
    verify("junk_len0", 1'b1);
    chk("len0_outputs", 64'({cmd_code, cmd_len, cmd_payload}), 64'({8'h07, 3'd0, 32'h0}));

    put(64'hA5_10_02_34_12_00, 6);
    model_and_send();
    drain(8);
    verify("badcsum", 1'b1);
    chk("badcsum_hold", 64'({cmd_code, err_code, tx_writedata}), 64'({8'h07, 2'd2, 8'h15}));

    put(64'hA5_10_05_A5_22_01_5A_79, 8);
    model_and_send();
    drain(8);
    verify("badlen", 1'b1);

    for (int f = 0; f < 40; f++) begin
      gap_pct = $urandom_range(0, 40);
      nj = $urandom_range(0, 3);
      for (int j = 0; j < nj; j++) begin
        b = 8'($urandom_range(0, 255));
        if (b == 8'hA5) b = 8'h5A;
        stim.push_back(b);
      end
      kind = $urandom_range(0, 7);
      stim.push_back(8'hA5);
      b = 8'($urandom_range(0, 255));
      stim.push_back(b);
      if (kind == 0) begin
        stim.push_back(8'($urandom_range(5, 255)));
      end else begin
        len = $urandom_range(0, 4);
        cs = b ^ 8'(len);
        stim.push_back(8'(len));
        for (int k = 0; k < len; k++) begin
          b = 8'($urandom_range(0, 255));
          cs = cs ^ b;
          stim.push_back(b);
        end
        if (kind == 1) stim.push_back(cs ^ 8'($urandom_range(1, 255)));
        else stim.push_back(cs);
      end
      model_and_send();
      drain(8);
      verify("rand", 1'b1);
    end
    gap_pct = 0;

    put(64'hA5_10, 2);
    send_raw();
    drain(25);
    chk("to_ev_count", 64'(ev_q.size() - ev_rd), 64'(1));
    if (ev_rd < ev_q.size()) begin
      o = ev_q[ev_rd];
      chk("to_strobe", 64'(o.good), 64'(0));
      chk("to_err", 64'(o.err), 64'(3));
      chk("to_latency", 64'(o.cyc - o.lrd), 64'(TO));
      chk("to_hold", 64'({o.code, o.len, o.pay}), 64'({held_code, held_len, held_pay}));
    end
    chk("to_no_tx", 64'(tx_q.size() - tx_rd), 64'(0));
    ev_rd = ev_q.size();
    held_err = 2'd3;
    put(64'hA5_33_00_33, 4);
    model_and_send();
    drain(8);
    verify("after_to", 1'b1);

    tx_wrfull = 1'b1;
    put(64'hA5_44_01_55_10, 5);
    model_and_send();
    drain(12);
    chk("full_hold", 64'(tx_q.size() - tx_rd), 64'(0));
    tx_wrfull = 1'b0;
    repeat (4) @(negedge clk);
    verify("full", 1'b0);

    put(64'hA5_66_03_11_22, 5);
    send_raw();
    drain(3);
    reset_n = 1'b0;
    #1;
    chk("midrst_strobes", 64'({rx_read, tx_write, cmd_valid, cmd_error}), 64'(0));
    chk("midrst_cmd", 64'({cmd_code, cmd_len, cmd_payload}), 64'(0));
    chk("midrst_err_tx", 64'({err_code, tx_writedata}), 64'(0));
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    held_code = 8'h00;
    held_len  = 3'd0;
    held_pay  = 32'h0;
    held_err  = 2'd0;
    repeat (30) @(negedge clk);
    chk("midrst_no_ev", 64'(ev_q.size() - ev_rd), 64'(0));
    chk("midrst_no_tx", 64'(tx_q.size() - tx_rd), 64'(0));
    put(64'hA5_77_01_08_7E, 5);
    model_and_send();
    drain(8);
    verify("after_rst", 1'b1);

    chk("no_overlap_or_full_write", 64'(anomaly), 64'(0));
    chk("no_underflow", 64'(underflow), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog expired");
  end

endmodule
